// File: rtl/sn74169_drv_pkg.sv
// Shared types and sizing for the SN74169 counter driver/checker.
package sn74169_drv_pkg;

    localparam int LEN_W = 8;
    localparam int CTR_W = 4;
    localparam logic [LEN_W-1:0] ERR_SAT = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sn74169_model.sv
// Reference model of the counter: expected Q value and expected ripple-carry.
// exp_val becomes load_val on the edge after load and steps once per enabled cycle.
module sn74169_model
    import sn74169_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             step,
    input  logic             up,
    output logic [CTR_W-1:0] exp_val,
    output logic             exp_rco_n
);

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_val <= '0;
        end else if (load) begin
            exp_val <= load_val;
        end else if (step) begin
            exp_val <= up ? exp_val + 1'b1 : exp_val - 1'b1;
        end
    end

    // Carry is only meaningful while the counter is enabled, i.e. while stepping.
    always_comb begin
        exp_rco_n = 1'b1;
        if (step && (up ? (exp_val == '1) : (exp_val == '0))) begin
            exp_rco_n = 1'b0;
        end
    end

endmodule

// File: rtl/sn74169_driver.sv
// Drives an SN74169 up/down counter through load/count runs and checks its Q (and,
// with SN74169_DRV_RCO_CHECK_EN defined, its ripple-carry) against a reference model.
module sn74169_driver
    import sn74169_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CTR_W-1:0] cmd_val,
    input  logic             cmd_up,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [CTR_W-1:0] ctr_q,
    input  logic             ctr_rco_n,
    output logic             ctr_load_n,
    output logic             ctr_enp_n,
    output logic             ctr_ent_n,
    output logic             ctr_ud,
    output logic [CTR_W-1:0] ctr_d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] err_count,
    output logic [LEN_W-1:0] wrap_count
);

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic [CTR_W-1:0] exp_val;
    logic             exp_rco_n;
    logic             accept;
    logic             counting;
    logic             q_bad;
    logic             rco_bad;
    logic [LEN_W-1:0] err_next;

    assign accept   = (state == ST_IDLE) && start;
    assign counting = (state == ST_COUNT);

    // ctr_ud is captured from cmd_up on accept, so it doubles as the run's direction.
    sn74169_model u_model (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_val  (cmd_val),
        .step      (counting),
        .up        (ctr_ud),
        .exp_val   (exp_val),
        .exp_rco_n (exp_rco_n)
    );

`ifdef SN74169_DRV_RCO_CHECK_EN
    assign rco_bad = counting && (ctr_rco_n != exp_rco_n);
`else
    logic unused_rco;
    assign unused_rco = ctr_rco_n;
    assign rco_bad    = 1'b0;
`endif

    always_comb begin
        q_bad    = ((state == ST_COUNT) || (state == ST_CHECK)) && (ctr_q != exp_val);
        err_next = err_count;
        if ((q_bad || rco_bad) && (err_count != ERR_SAT)) begin
            err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rem        <= '0;
            ctr_load_n <= 1'b1;
            ctr_enp_n  <= 1'b1;
            ctr_ent_n  <= 1'b1;
            ctr_ud     <= 1'b1;
            ctr_d      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        rem        <= cmd_len;
                        ctr_load_n <= 1'b0;
                        ctr_d      <= cmd_val;
                        ctr_ud     <= cmd_up;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        wrap_count <= '0;
                    end
                end
                ST_LOAD: begin
                    ctr_load_n <= 1'b1;
                    if (rem != '0) begin
                        state     <= ST_COUNT;
                        ctr_enp_n <= 1'b0;
                        ctr_ent_n <= 1'b0;
                    end else begin
                        state <= ST_CHECK;
                    end
                end
                ST_COUNT: begin
                    err_count <= err_next;
                    if (!exp_rco_n) begin
                        wrap_count <= wrap_count + 1'b1;
                    end
                    rem <= rem - 1'b1;
                    if (rem == 8'd1) begin
                        state     <= ST_CHECK;
                        ctr_enp_n <= 1'b1;
                        ctr_ent_n <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next;
                    pass      <= (err_next == '0);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sn74169_driver.sv
// Bench for sn74169_driver: behavioural SN74169 plus a scoreboard checked on each done pulse.
module tb_sn74169_driver;

    typedef struct packed {
        logic [31:0] start_cyc;
        logic [7:0]  len;
        logic [7:0]  err;
        logic [7:0]  wrap;
        logic        pass;
        logic [4:0]  nq;
        logic [63:0] qs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cmd_val;
    logic       cmd_up;
    logic [7:0] cmd_len;
    logic [3:0] ctr_q;
    logic       ctr_rco_n;
    logic       ctr_load_n, ctr_enp_n, ctr_ent_n, ctr_ud;
    logic [3:0] ctr_d;
    logic       busy, done, pass;
    logic [7:0] err_count, wrap_count;

    logic [3:0] cq;
    logic       stuck;
    logic       force_rco;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       sb[$];
    logic [63:0] obs_qs;
    int          obs_n;

    sn74169_driver dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd_val    (cmd_val),
        .cmd_up     (cmd_up),
        .cmd_len    (cmd_len),
        .ctr_q      (ctr_q),
        .ctr_rco_n  (ctr_rco_n),
        .ctr_load_n (ctr_load_n),
        .ctr_enp_n  (ctr_enp_n),
        .ctr_ent_n  (ctr_ent_n),
        .ctr_ud     (ctr_ud),
        .ctr_d      (ctr_d),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural counter: synchronous load, count when both enables are low.
    always @(posedge clk) begin
        if (rst && ctr_load_n) cq <= 4'd0;
        else if (!ctr_load_n) cq <= ctr_d;
        else if (!ctr_enp_n && !ctr_ent_n) cq <= ctr_ud ? cq + 4'd1 : cq - 4'd1;
    end

    assign ctr_q     = stuck ? 4'd5 : cq;
    assign ctr_rco_n = force_rco ? 1'b1
                     : ~(!ctr_ent_n && (ctr_ud ? (ctr_q == 4'd15) : (ctr_q == 4'd0)));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] len, input logic [7:0] err,
                                input logic [7:0] wrap, input logic ps,
                                input logic [4:0] nq, input logic [63:0] qs);
        exp_t e;
        e.start_cyc = 0;
        e.len = len; e.err = err; e.wrap = wrap; e.pass = ps; e.nq = nq; e.qs = qs;
        return e;
    endfunction

    // Monitor: log Q in every checked cycle, compare a whole run on done.
    initial begin
        exp_t e;
        obs_qs = '0;
        obs_n  = 0;
        forever begin
            @(negedge clk);
            if (!ctr_load_n) begin
                obs_qs = '0;
                obs_n  = 0;
            end
            if (busy && (!ctr_enp_n || (ctr_load_n && ctr_enp_n)) && obs_n < 16) begin
                obs_qs[4*obs_n +: 4] = ctr_q;
                obs_n++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    e = sb.pop_front();
                    check("latency", 64'(cyc - int'(e.start_cyc)), 64'(int'(e.len) + 3));
                    check("err_count", 64'(err_count), 64'(e.err));
                    check("wrap_count", 64'(wrap_count), 64'(e.wrap));
                    check("pass", 64'(pass), 64'(e.pass));
                    check("num_q_checks", 64'(obs_n), 64'(e.nq));
                    check("q_sequence", obs_qs, e.qs);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, n);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    // Issue one start pulse at the current negedge; inputs are scrambled afterwards.
    task automatic issue(input logic [3:0] v, input logic up, input logic [7:0] len,
                         input logic do_push, input exp_t e);
        exp_t ee = e;
        cmd_val = v;
        cmd_up  = up;
        cmd_len = len;
        start   = 1'b1;
        ee.start_cyc = 32'(cyc);
        if (do_push) sb.push_back(ee);
        @(negedge clk);
        start   = 1'b0;
        cmd_val = ~v;
        cmd_up  = ~up;
        cmd_len = 8'd200;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_n"}, 64'(ctr_load_n), 64'd1);
        check({tag, "_enp_n"}, 64'(ctr_enp_n), 64'd1);
        check({tag, "_ent_n"}, 64'(ctr_ent_n), 64'd1);
        check({tag, "_ud"}, 64'(ctr_ud), 64'd1);
        check({tag, "_d"}, 64'(ctr_d), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
        check({tag, "_wrap"}, 64'(wrap_count), 64'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; cmd_val = 4'd0; cmd_up = 1'b1; cmd_len = 8'd0;
        stuck = 1'b0; force_rco = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // 14 up x3: wraps through 15 once.
        issue(4'd14, 1'b1, 8'd3, 1'b1, mk(8'd3, 8'd0, 8'd1, 1'b1, 5'd4, 64'h10FE));
        wait_idle();

        // 1 down x4: wraps through 0 once.
        issue(4'd1, 1'b0, 8'd4, 1'b1, mk(8'd4, 8'd0, 8'd1, 1'b1, 5'd5, 64'hDEF01));
        wait_idle();

        // Counter stuck at 5: second COUNT cycle and CHECK mismatch.
        stuck = 1'b1;
        issue(4'd5, 1'b1, 8'd2, 1'b1, mk(8'd2, 8'd2, 8'd0, 1'b0, 5'd3, 64'h555));
        wait_idle();
        stuck = 1'b0;

        // Zero length: load then a single check.
        issue(4'd9, 1'b1, 8'd0, 1'b1, mk(8'd0, 8'd0, 8'd0, 1'b1, 5'd1, 64'h9));
        wait_idle();

        // Reset in the middle of a long run.
        issue(4'd2, 1'b1, 8'd10, 1'b0, mk(8'd10, 8'd0, 8'd0, 1'b0, 5'd0, 64'h0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrun");
        wait_idle();
        issue(4'd3, 1'b1, 8'd5, 1'b1, mk(8'd5, 8'd0, 8'd0, 1'b1, 5'd6, 64'h876543));
        wait_idle();

        // RCO held inactive at the 15->0 step.
        force_rco = 1'b1;
`ifdef SN74169_DRV_RCO_CHECK_EN
        e = mk(8'd1, 8'd1, 8'd1, 1'b0, 5'd2, 64'h0F);
`else
        e = mk(8'd1, 8'd0, 8'd1, 1'b1, 5'd2, 64'h0F);
`endif
        issue(4'd15, 1'b1, 8'd1, 1'b1, e);
        wait_idle();
        force_rco = 1'b0;

        // Start raised in DONE and held into IDLE: exactly one run, starting from IDLE.
        issue(4'd7, 1'b1, 8'd2, 1'b1, mk(8'd2, 8'd0, 8'd0, 1'b1, 5'd3, 64'h987));
        wait_done();
        cmd_val = 4'd10; cmd_up = 1'b0; cmd_len = 8'd1; start = 1'b1;
        e = mk(8'd1, 8'd0, 8'd0, 1'b1, 5'd2, 64'h9A);
        e.start_cyc = 32'(cyc + 1);
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; cmd_val = 4'd0; cmd_up = 1'b1; cmd_len = 8'd77;
        wait_idle();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
